post_normalise64: RTL and testbench

POST_NORMALISE64 -- requirements
Module: post_normalise64

---
 rtl/fp64_pkg.sv | 15 +
 rtl/rne_round64.sv | 40 ++++
 rtl/post_normalise64.sv | 164 ++++++++++++++++
 tb/tb_post_normalise64.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// Shared types and IEEE-754 double constants for the post-normalisation stage.
package fp64_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StDone
  } state_e;

  localparam logic [10:0] EXP_MAX = 11'h7FF;
  localparam logic [10:0] BIAS    = 11'h3FF;
  localparam logic [63:0] QNAN64  = 64'h7FF8000000000000;

endpackage

// File: rtl/rne_round64.sv
// Round-to-nearest-even increment on a normalised significand, with the
// significand-overflow renormalisation and exponent-overflow detection.
module rne_round64
  import fp64_pkg::*;
#(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input  logic [MAN_W:0]   i_sum,
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
  input  logic [EXP_W-1:0] i_exp,
  output logic [MAN_W:0]   o_sum,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_inf,
  output logic             o_inexact
);

  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  logic             w_inc;
  logic [MAN_W+1:0] w_sum_rnd;

  always_comb begin
    w_inc     = i_g & (i_r | i_s | i_sum[0]);
    w_sum_rnd = {1'b0, i_sum} + {{(MAN_W + 1){1'b0}}, w_inc};
    // A carry out of the top bit means the significand was all ones: renormalise.
    if (w_sum_rnd[MAN_W+1]) begin
      o_sum = w_sum_rnd[MAN_W+1:1];
      o_exp = i_exp + ExpOne;
    end else begin
      o_sum = w_sum_rnd[MAN_W:0];
      o_exp = i_exp;
    end
    o_inf     = (o_exp == EXP_MAX);
    o_inexact = i_g | i_r | i_s;
  end

endmodule

// File: rtl/post_normalise64.sv
// Post-adder normalisation for IEEE-754 doubles: special-case handling,
// iterative one-bit-per-cycle left shift, then round-to-nearest-even.
module post_normalise64
  import fp64_pkg::*;
#(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [MAN_W:0]       sumIn,
  input  logic                 carryIn,
  input  logic [2:0]           grsIn,
  input  logic [EXP_W-1:0]     expIn,
  input  logic                 signIn,
  input  logic                 nanIn,
  input  logic                 infIn,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ready,
  output logic                 busy,
  output logic                 inexact
);

  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  state_e                 r_state, w_state_d;
  logic [MAN_W:0]         r_sum, w_sum_d;
  logic                   r_g, w_g_d;
  logic                   r_r, w_r_d;
  logic                   r_s, w_s_d;
  logic [EXP_W-1:0]       r_exp, w_exp_d;
  logic                   r_sign, w_sign_d;
  logic [EXP_W+MAN_W:0]   r_result, w_result_d;
  logic                   r_inexact, w_inexact_d;

  logic [EXP_W-1:0]       w_exp_inc;
  logic [MAN_W:0]         w_rnd_sum;
  logic [EXP_W-1:0]       w_rnd_exp;
  logic                   w_rnd_inf;
  logic                   w_rnd_inexact;
  logic [EXP_W-1:0]       w_field;

  rne_round64 #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_rne_round64 (
    .i_sum     (r_sum),
    .i_g       (r_g),
    .i_r       (r_r),
    .i_s       (r_s),
    .i_exp     (r_exp),
    .o_sum     (w_rnd_sum),
    .o_exp     (w_rnd_exp),
    .o_inf     (w_rnd_inf),
    .o_inexact (w_rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_sum     <= '0;
      r_g       <= 1'b0;
      r_r       <= 1'b0;
      r_s       <= 1'b0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_result  <= '0;
      r_inexact <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_sum     <= w_sum_d;
      r_g       <= w_g_d;
      r_r       <= w_r_d;
      r_s       <= w_s_d;
      r_exp     <= w_exp_d;
      r_sign    <= w_sign_d;
      r_result  <= w_result_d;
      r_inexact <= w_inexact_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_sum_d     = r_sum;
    w_g_d       = r_g;
    w_r_d       = r_r;
    w_s_d       = r_s;
    w_exp_d     = r_exp;
    w_sign_d    = r_sign;
    w_result_d  = r_result;
    w_inexact_d = r_inexact;
    w_exp_inc   = expIn + ExpOne;
    // A significand whose hidden bit is still clear after shifting is subnormal.
    w_field     = w_rnd_sum[MAN_W] ? w_rnd_exp : '0;

    if (en) begin
      case (r_state)
        StIdle, StDone: begin
          if (load) begin
            w_sign_d    = signIn;
            w_inexact_d = 1'b0;
            w_sum_d     = sumIn;
            w_g_d       = grsIn[2];
            w_r_d       = grsIn[1];
            w_s_d       = grsIn[0];
            w_exp_d     = expIn;
            if (nanIn) begin
              w_result_d = QNAN64;
              w_state_d  = StDone;
            end else if (infIn) begin
              w_result_d = {signIn, EXP_MAX, {MAN_W{1'b0}}};
              w_state_d  = StDone;
            end else if (carryIn) begin
              if (w_exp_inc == EXP_MAX) begin
                w_result_d  = {signIn, EXP_MAX, {MAN_W{1'b0}}};
                w_inexact_d = 1'b1;
                w_state_d   = StDone;
              end else begin
                w_sum_d   = {carryIn, sumIn[MAN_W:1]};
                w_g_d     = sumIn[0];
                w_r_d     = grsIn[2];
                w_s_d     = grsIn[1] | grsIn[0];
                w_exp_d   = w_exp_inc;
                w_state_d = StShift;
              end
            end else if (sumIn == '0 && grsIn == 3'b000) begin
              w_result_d = {signIn, {(EXP_W + MAN_W){1'b0}}};
              w_state_d  = StDone;
            end else begin
              w_state_d = StShift;
            end
          end
        end
        StShift: begin
          if (r_sum[MAN_W] || r_exp <= ExpOne) begin
            w_state_d = StRound;
          end else begin
            w_sum_d = {r_sum[MAN_W-1:0], r_g};
            w_g_d   = r_r;
            w_r_d   = 1'b0;
            w_exp_d = r_exp - ExpOne;
          end
        end
        StRound: begin
          w_result_d  = w_rnd_inf ? {r_sign, EXP_MAX, {MAN_W{1'b0}}}
                                  : {r_sign, w_field, w_rnd_sum[MAN_W-1:0]};
          w_inexact_d = w_rnd_inexact;
          w_state_d   = StDone;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ready   = (r_state == StDone);
    busy    = (r_state == StShift) || (r_state == StRound);
    result  = r_result;
    inexact = r_inexact;
  end

endmodule

// File: tb/tb_post_normalise64.sv
// Directed self-checking bench for post_normalise64 with hand-computed results.
module tb_post_normalise64;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [52:0] sumIn;
  logic        carryIn;
  logic [2:0]  grsIn;
  logic [10:0] expIn;
  logic        signIn;
  logic        nanIn;
  logic        infIn;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  logic        inexact;

  int n_pass  = 0;
  int n_total = 0;

  post_normalise64 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .sumIn   (sumIn),
    .carryIn (carryIn),
    .grsIn   (grsIn),
    .expIn   (expIn),
    .signIn  (signIn),
    .nanIn   (nanIn),
    .infIn   (infIn),
    .result  (result),
    .ready   (ready),
    .busy    (busy),
    .inexact (inexact)
  );

  always #5 clk = ~clk;

  // Presents one operation and returns 1 ns after its capture edge.
  task automatic start_op(input logic [52:0] s, input logic c, input logic [2:0] grs,
                          input logic [10:0] e, input logic sg, input logic nan,
                          input logic inf);
    sumIn = s; carryIn = c; grsIn = grs; expIn = e; signIn = sg; nanIn = nan; infIn = inf;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; nanIn = 1'b0; infIn = 1'b0;
  endtask

  // Counts further edges until ready, bounded by max_edges.
  task automatic wait_ready(input int max_edges, output int edges);
    edges = 0;
    while (!ready && edges < max_edges) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; load = 1'b0; sumIn = '0; carryIn = 1'b0; grsIn = '0;
    expIn = '0; signIn = 1'b0; nanIn = 1'b0; infIn = 1'b0;
    #12;
    n_total++; if (result !== 64'h0) $display("FAIL reset_result got %h want 0", result);
    else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready);
    else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    n_total++; if (inexact !== 1'b0) $display("FAIL reset_inexact got %b want 0", inexact);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_one;
    int edges;
    start_op(53'h10000000000000, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b0);
    n_total++; if (busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL one_busy got busy=%b ready=%b want 1/0", busy, ready);
    else n_pass++;
    wait_ready(10, edges);
    n_total++; if (edges !== 2) $display("FAIL one_latency got %0d want 2", edges);
    else n_pass++;
    n_total++; if (result !== 64'h3FF0000000000000)
      $display("FAIL one_result got %h want 3ff0000000000000", result);
    else n_pass++;
    n_total++; if (inexact !== 1'b0) $display("FAIL one_inexact got %b want 0", inexact);
    else n_pass++;
  endtask

  task automatic test_carry;
    int edges;
    start_op(53'h10000000000000, 1'b1, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 2) $display("FAIL carry_latency got %0d want 2", edges);
    else n_pass++;
    n_total++; if (result !== 64'h4008000000000000)
      $display("FAIL carry_result got %h want 4008000000000000", result);
    else n_pass++;
  endtask

  task automatic test_shift52;
    int edges;
    start_op(53'h1, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b0);
    wait_ready(70, edges);
    n_total++; if (edges !== 54) $display("FAIL shift52_latency got %0d want 54", edges);
    else n_pass++;
    n_total++; if (result !== 64'h3CB0000000000000)
      $display("FAIL shift52_result got %h want 3cb0000000000000", result);
    else n_pass++;
  endtask

  task automatic test_rounding;
    int edges;
    start_op(53'h1FFFFFFFFFFFFF, 1'b0, 3'b100, 11'h3FE, 1'b0, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (result !== 64'h3FF0000000000000 || inexact !== 1'b1)
      $display("FAIL round_ovf got %h/%b want 3ff0000000000000/1", result, inexact);
    else n_pass++;
    // Exact tie on an even significand stays put.
    start_op(53'h10000000000000, 1'b0, 3'b100, 11'h3FF, 1'b0, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (result !== 64'h3FF0000000000000 || inexact !== 1'b1)
      $display("FAIL tie_even got %h/%b want 3ff0000000000000/1", result, inexact);
    else n_pass++;
    start_op(53'h10000000000001, 1'b0, 3'b100, 11'h3FF, 1'b1, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (result !== 64'hBFF0000000000002 || inexact !== 1'b1)
      $display("FAIL tie_odd got %h/%b want bff0000000000002/1", result, inexact);
    else n_pass++;
    // One left shift pulls g into the LSB, then the round overflows.
    start_op(53'h0FFFFFFFFFFFFF, 1'b0, 3'b110, 11'h3FF, 1'b0, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 3) $display("FAIL shift_grs_latency got %0d want 3", edges);
    else n_pass++;
    n_total++; if (result !== 64'h3FF0000000000000 || inexact !== 1'b1)
      $display("FAIL shift_grs got %h/%b want 3ff0000000000000/1", result, inexact);
    else n_pass++;
  endtask

  task automatic test_subnormal;
    int edges;
    start_op(53'h1, 1'b0, 3'b000, 11'h003, 1'b0, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 4) $display("FAIL subn_latency got %0d want 4", edges);
    else n_pass++;
    n_total++; if (result !== 64'h0000000000000004)
      $display("FAIL subn_result got %h want 0000000000000004", result);
    else n_pass++;
  endtask

  task automatic test_special;
    int edges;
    start_op(53'h10000000000000, 1'b1, 3'b000, 11'h7FE, 1'b1, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 0 || result !== 64'hFFF0000000000000 || inexact !== 1'b1)
      $display("FAIL carry_inf got %0d/%h/%b want 0/fff0000000000000/1", edges, result,
               inexact);
    else n_pass++;
    start_op(53'h12345, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b1, 1'b1);
    wait_ready(10, edges);
    n_total++; if (edges !== 0 || result !== 64'h7FF8000000000000 || inexact !== 1'b0)
      $display("FAIL nan got %0d/%h/%b want 0/7ff8000000000000/0", edges, result, inexact);
    else n_pass++;
    start_op(53'h12345, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b1);
    wait_ready(10, edges);
    n_total++; if (edges !== 0 || result !== 64'h7FF0000000000000)
      $display("FAIL inf got %0d/%h want 0/7ff0000000000000", edges, result);
    else n_pass++;
    start_op(53'h0, 1'b0, 3'b000, 11'h3FF, 1'b1, 1'b0, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 0 || result !== 64'h8000000000000000 || busy !== 1'b0)
      $display("FAIL zero got %0d/%h/%b want 0/8000000000000000/0", edges, result, busy);
    else n_pass++;
  endtask

  task automatic test_busy_ignore;
    int edges;
    start_op(53'h10000000000000, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b0);
    nanIn = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    nanIn = 1'b0; load = 1'b0;
    wait_ready(10, edges);
    n_total++; if (edges !== 1 || result !== 64'h3FF0000000000000)
      $display("FAIL busy_ignore got %0d/%h want 1/3ff0000000000000", edges, result);
    else n_pass++;
  endtask

  task automatic test_enable;
    int edges;
    start_op(53'h10000000000000, 1'b0, 3'b000, 11'h3FE, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL en_freeze got busy=%b ready=%b want 1/0", busy, ready);
    else n_pass++;
    en = 1'b1;
    wait_ready(10, edges);
    n_total++; if (edges !== 2 || result !== 64'h3FE0000000000000)
      $display("FAIL en_resume got %0d/%h want 2/3fe0000000000000", edges, result);
    else n_pass++;
    en = 1'b0;
    start_op(53'h0, 1'b0, 3'b000, 11'h0, 1'b0, 1'b1, 1'b0);
    n_total++; if (ready !== 1'b1 || result !== 64'h3FE0000000000000)
      $display("FAIL en_load_blocked got %b/%h want 1/3fe0000000000000", ready, result);
    else n_pass++;
    en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int edges;
    start_op(53'h1, 1'b0, 3'b000, 11'h3FF, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'h0 || inexact !== 1'b0)
      $display("FAIL reset_mid got r=%b b=%b %h i=%b want 0/0/0/0", ready, busy, result,
               inexact);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    start_op(53'h0, 1'b0, 3'b000, 11'h0, 1'b0, 1'b1, 1'b0);
    wait_ready(10, edges);
    n_total++; if (edges !== 0 || result !== 64'h7FF8000000000000)
      $display("FAIL post_reset_capture got %0d/%h want 0/7ff8000000000000", edges, result);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_one;
    test_carry;
    test_shift52;
    test_rounding;
    test_subnormal;
    test_special;
    test_busy_ignore;
    test_enable;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
